// File: rtl/heater_share_arbiter.sv
// Round-robin heater supply arbiter for four incubator chambers.
// Grants carry a minimum dwell, a maximum hold with forced release, and a guard gap.
module heater_share_arbiter #(
    parameter int DWELL   = 16,
    parameter int MAXHOLD = 32,
    parameter int GAP     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic       preempt
);

    typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;

    localparam logic [7:0] L_DWELL   = 8'(DWELL);
    localparam logic [7:0] L_MAXHOLD = 8'(MAXHOLD);
    localparam logic [7:0] L_GAP     = 8'(GAP);
    localparam bit         L_EQUAL   = (DWELL == MAXHOLD);

    state_t     r_state;
    logic [1:0] r_ptr;
    logic [7:0] r_cnt;
    logic [7:0] r_gcnt;

    logic [1:0] w_sel;
    logic       w_any;
    logic       w_max;
    logic       w_soft;

    always_comb begin
        w_sel = '0;
        w_any = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!w_any && req[r_ptr + 2'(i)]) begin
                w_any = 1'b1;
                w_sel = r_ptr + 2'(i);
            end
        end
    end

    assign w_max  = (r_cnt >= L_MAXHOLD);
    assign w_soft = (r_cnt >= L_DWELL) && (!req[grant_id] || !en);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_gcnt   <= '0;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            preempt  <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (r_state)
                IDLE: begin
                    busy <= 1'b0;
                    if (en && w_any) begin
                        grant    <= 4'b0001 << w_sel;
                        grant_id <= w_sel;
                        busy     <= 1'b1;
                        r_cnt    <= 8'd1;
                        r_state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_max || w_soft) begin
                        grant   <= '0;
                        r_ptr   <= grant_id + 2'd1;
                        r_cnt   <= '0;
                        // With DWELL==MAXHOLD a voluntary release at the same edge is not a preemption
                        preempt <= w_max && !(L_EQUAL && w_soft);
                        if (GAP > 0) begin
                            r_gcnt  <= 8'd1;
                            r_state <= GUARD;
                        end else begin
                            busy    <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                GUARD: begin
                    if (r_gcnt >= L_GAP) begin
                        busy    <= 1'b0;
                        r_gcnt  <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_gcnt <= r_gcnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_heater_share_arbiter.sv
// Scoreboard bench for heater_share_arbiter: stimulus queues expected grants,
// a negedge monitor measures each grant and compares on release.
module tb_heater_share_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       preempt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0] id;
        int         len;
        logic       pre;
        int         gap;   // -1 means the preceding low time is not checked
    } exp_t;

    exp_t q[$];

    heater_share_arbiter #(.DWELL(16), .MAXHOLD(32), .GAP(4)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .grant(grant), .grant_id(grant_id), .busy(busy), .preempt(preempt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] id, input int len, input logic pre, input int gap);
        exp_t e;
        e.id = id; e.len = len; e.pre = pre; e.gap = gap;
        q.push_back(e);
    endtask

    logic [3:0] m_prev;
    logic [1:0] m_id;
    logic       m_prev_pre;
    int         m_len, m_gap, m_gap_rise;

    always @(negedge clk) begin
        if (!rst) begin
            m_prev     = '0;
            m_prev_pre = 1'b0;
            m_len      = 0;
            m_gap      = -1;
        end else begin
            n_cmp++;
            if (!$onehot0(grant)) begin
                n_bad++;
                $display("FAIL onehot: grant=%b", grant);
            end
            if (m_prev_pre) begin
                n_cmp++;
                if (preempt) begin
                    n_bad++;
                    $display("FAIL preempt_width: preempt high two cycles, expected one");
                end
            end
            if (grant != 4'b0 && m_prev == 4'b0) begin
                for (int i = 0; i < 4; i++) if (grant[i]) m_id = 2'(i);
                m_len      = 1;
                m_gap_rise = m_gap;
                m_gap      = -1;
                n_cmp++;
                if (grant_id !== m_id) begin
                    n_bad++;
                    $display("FAIL grant_id: got %0d, expected %0d", grant_id, m_id);
                end
            end else if (grant != 4'b0) begin
                m_len++;
            end else if (m_prev != 4'b0) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL guard_busy: got %b, expected 1", busy);
                end
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_grant: id=%0d len=%0d, expected none", m_id, m_len);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (m_id !== e.id || m_len != e.len || preempt !== e.pre ||
                        (e.gap >= 0 && m_gap_rise != e.gap)) begin
                        n_bad++;
                        $display("FAIL grant_rec: got id=%0d len=%0d pre=%b gap=%0d, expected id=%0d len=%0d pre=%b gap=%0d",
                                 m_id, m_len, preempt, m_gap_rise, e.id, e.len, e.pre, e.gap);
                    end
                end
                m_gap = 0;
            end
            if (grant == 4'b0 && m_gap >= 0) m_gap++;
            m_prev_pre = preempt;
            m_prev     = grant;
        end
    end

    initial begin
        int blocked;
        rst = 1'b0; en = 1'b0; req = '0;
        tick(3);
        chk("rst_grant", grant, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_preempt", preempt, 0);
        rst = 1'b1; en = 1'b1;
        tick(2);

        // Held request: two full MAXHOLD grants to chamber 2, 5 low cycles between
        push(2'd2, 32, 1'b1, -1);
        push(2'd2, 32, 1'b1, 5);
        req = 4'b0100;
        tick(1);
        chk("latency_grant", grant, 4'b0100);
        chk("latency_busy", busy, 1);
        tick(69);
        req = '0;
        tick(12);

        // Short request: exactly DWELL cycles, no preempt
        push(2'd1, 16, 1'b0, -1);
        req = 4'b0010;
        tick(3);
        req = '0;
        tick(30);
        chk("idle_busy_after_short", busy, 0);

        // All requesting from ptr=0: rotation 0,1,2,3,0
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
        push(2'd0, 32, 1'b1, -1);
        push(2'd1, 32, 1'b1, 5);
        push(2'd2, 32, 1'b1, 5);
        push(2'd3, 32, 1'b1, 5);
        push(2'd0, 32, 1'b1, 5);
        req = 4'b1111;
        tick(181);
        req = '0;
        tick(12);

        // Pointer after a chamber 2 grant sits at 3
        push(2'd2, 16, 1'b0, -1);
        req = 4'b0100;
        tick(3);
        req = '0;
        tick(25);
        push(2'd3, 32, 1'b1, -1);
        push(2'd0, 32, 1'b1, 5);
        req = 4'b1001;
        tick(1);
        chk("ptr_first_grant", grant, 4'b1000);
        tick(69);
        req = '0;
        tick(12);

        // Asynchronous reset mid-grant
        req = 4'b0001;
        tick(6);
        chk("pre_reset_grant", grant, 4'b0001);
        rst = 1'b0;
        #1;
        chk("async_grant", grant, 0);
        chk("async_busy", busy, 0);
        chk("async_preempt", preempt, 0);
        req = 4'b1000;
        tick(2);
        chk("held_reset_grant", grant, 0);
        push(2'd3, 16, 1'b0, -1);
        rst = 1'b1;
        tick(1);
        chk("post_reset_grant", grant, 4'b1000);
        chk("post_reset_id", grant_id, 3);
        req = '0;
        tick(30);

        // en low blocks grants; en falling mid-grant keeps DWELL
        en = 1'b0;
        req = 4'b0001;
        blocked = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (grant != 4'b0 || busy) blocked++;
        end
        chk("en_low_no_grant", blocked, 0);
        push(2'd0, 16, 1'b0, -1);
        en = 1'b1;
        tick(1);
        chk("en_grant", grant, 4'b0001);
        tick(4);
        en = 1'b0;
        tick(30);
        chk("en_low_after", grant, 0);
        chk("en_low_busy", busy, 0);
        req = '0;
        en = 1'b1;

        for (int i = 0; i < 200 && q.size() != 0; i++) tick(1);
        chk("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
